// File: rtl/voxel_pkg.sv
// Shared voxel-display definitions: scheduler states, latch-select encoding
// and the default encoder resolution.
package voxel_pkg;

  localparam int NUM_SLICES_DEFAULT = 360;

  localparam logic LATCH_SEL_CTRL = 1'b1;
  localparam logic LATCH_SEL_GS   = 1'b0;

  typedef enum logic [2:0] {
    INIT_CTRL  = 3'd0,
    INIT_WAIT  = 3'd1,
    IDLE       = 3'd2,
    GS_ISSUE   = 3'd3,
    GS_WAIT    = 3'd4,
    CTRL_ISSUE = 3'd5,
    CTRL_WAIT  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// the one-cycle pulse appears three clocks after the asynchronous edge.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q;
  logic       hist_q;

  // NOTE: every flop here uses <= so all stages sample the pre-edge values;
  // blocking assignments would collapse the chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      hist_q <= sync_q[1];
      rise   <= sync_q[1] & ~hist_q;
    end
  end

endmodule

// File: rtl/latch_scheduler.sv
// Decides when the shift engine reloads the control or grayscale latch,
// tracking the encoder slice and flagging slices that were never displayed.
module latch_scheduler
  import voxel_pkg::*;
#(
  parameter int NUM_SLICES = NUM_SLICES_DEFAULT,
  parameter int SW         = $clog2(NUM_SLICES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enc_tick,
  input  logic          enc_home,
  input  logic          ctrl_req,
  input  logic          shift_busy,
  input  logic          shift_done,
  output logic          shift_start,
  output logic          shift_sel,
  output logic [SW-1:0] gs_slice,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic [2:0]    sched_state
);

  logic          tick_ev;
  logic          home_ev;
  logic [SW-1:0] cur_slice;
  logic          ctrl_pend;
  logic          gs_pend;
  logic          issue_fire;
  logic          issue_sel;
  logic          gs_issue;
  logic          ctrl_issue;

  sched_state_t state_q;
  sched_state_t state_d;

  sync_edge u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (enc_tick),
    .rise     (tick_ev)
  );

  sync_edge u_home_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (enc_home),
    .rise     (home_ev)
  );

  assign gs_issue    = issue_fire && (issue_sel == LATCH_SEL_GS);
  assign ctrl_issue  = issue_fire && (issue_sel == LATCH_SEL_CTRL);
  assign sched_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_slice <= '0;
    end else if (home_ev) begin
      cur_slice <= '0;
    end else if (tick_ev) begin
      cur_slice <= (cur_slice == SW'(NUM_SLICES - 1)) ? '0 : cur_slice + SW'(1);
    end
  end

  // New requests win over a same-cycle issue so nothing arriving mid-issue is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gs_pend   <= 1'b0;
      ctrl_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick_ev || home_ev) gs_pend <= 1'b1;
      else if (gs_issue)      gs_pend <= 1'b0;

      if (ctrl_req)        ctrl_pend <= 1'b1;
      else if (ctrl_issue) ctrl_pend <= 1'b0;

      if (tick_ev && gs_pend) overrun <= 1'b1;
      else if (overrun_clr)   overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= INIT_CTRL;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment before the case keeps every path assigned,
  // so no latch is inferred for state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_CTRL:  state_d = INIT_WAIT;
      INIT_WAIT:  if (shift_done) state_d = IDLE;
      IDLE: begin
        if (gs_pend)        state_d = GS_ISSUE;
        else if (ctrl_pend) state_d = CTRL_ISSUE;
      end
      GS_ISSUE:   if (!shift_busy) state_d = GS_WAIT;
      GS_WAIT:    if (shift_done) state_d = IDLE;
      CTRL_ISSUE: if (!shift_busy) state_d = CTRL_WAIT;
      CTRL_WAIT:  if (shift_done) state_d = IDLE;
      default:    state_d = INIT_CTRL;
    endcase
  end

  // The initial control load goes out unconditionally: after reset the engine
  // is assumed restarted too, so shift_busy is not trusted there.
  always_comb begin
    issue_fire = 1'b0;
    issue_sel  = LATCH_SEL_CTRL;
    unique case (state_q)
      INIT_CTRL: begin
        issue_fire = 1'b1;
        issue_sel  = LATCH_SEL_CTRL;
      end
      GS_ISSUE: begin
        issue_fire = !shift_busy;
        issue_sel  = LATCH_SEL_GS;
      end
      CTRL_ISSUE: begin
        issue_fire = !shift_busy;
        issue_sel  = LATCH_SEL_CTRL;
      end
      default: begin
        issue_fire = 1'b0;
        issue_sel  = LATCH_SEL_CTRL;
      end
    endcase
  end

  // Command outputs are registered; shift_sel and gs_slice hold until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_start <= 1'b0;
      shift_sel   <= LATCH_SEL_CTRL;
      gs_slice    <= '0;
    end else begin
      shift_start <= issue_fire;
      if (issue_fire) shift_sel <= issue_sel;
      if (gs_issue)   gs_slice  <= cur_slice;
    end
  end

endmodule

// File: tb/tb_latch_scheduler.sv
// Scoreboard bench for latch_scheduler: a behavioural shift engine pops the
// expected upload on every shift_start and answers with busy/done.
module tb_latch_scheduler;
  import voxel_pkg::*;

  localparam int NS = 360;
  localparam int SW = 9;

  typedef struct packed {
    logic          sel;
    logic [SW-1:0] slice;
  } upload_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enc_tick = 1'b0;
  logic          enc_home = 1'b0;
  logic          ctrl_req = 1'b0;
  logic          shift_busy = 1'b0;
  logic          shift_done = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          shift_start;
  logic          shift_sel;
  logic [SW-1:0] gs_slice;
  logic          overrun;
  logic [2:0]    sched_state;

  upload_t       sb[$];
  int            checks = 0;
  int            failures = 0;
  int            starts = 0;
  int            done_delay = 20;
  int            model_slice = 0;
  logic [SW-1:0] held_slice = '0;

  always #5 clk = ~clk;

  latch_scheduler #(.NUM_SLICES(NS), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_tick    (enc_tick),
    .enc_home    (enc_home),
    .ctrl_req    (ctrl_req),
    .shift_busy  (shift_busy),
    .shift_done  (shift_done),
    .shift_start (shift_start),
    .shift_sel   (shift_sel),
    .gs_slice    (gs_slice),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .sched_state (sched_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic sel, input int slice);
    upload_t e;
    e.sel   = sel;
    e.slice = SW'(slice);
    sb.push_back(e);
  endtask

  task automatic tick_pulse();
    enc_tick = 1'b1;
    repeat (2) @(negedge clk);
    enc_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick_gs();
    model_slice = (model_slice + 1) % NS;
    push(LATCH_SEL_GS, model_slice);
    tick_pulse();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    while (n < budget && !(sched_state == IDLE && !shift_busy && sb.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    check({tag, "_idle"}, sched_state, IDLE);
  endtask

  task automatic wait_state(input sched_state_t s, input int budget);
    int n = 0;
    while (n < budget && sched_state != s) begin
      @(negedge clk);
      n++;
    end
    check("reach_state", sched_state, s);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"},   shift_start, 0);
    check({tag, "_sel"},     shift_sel, 1);
    check({tag, "_slice"},   gs_slice, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_state"},   sched_state, INIT_CTRL);
  endtask

  // Behavioural shift engine: one scoreboard pop per start, done after done_delay.
  initial begin
    int      cnt;
    upload_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      shift_done = 1'b0;
      if (reset) begin
        shift_busy = 1'b0;
        cnt = 0;
      end else if (cnt > 0) begin
        if (cnt == done_delay) check("start_width", shift_start, 0);
        cnt--;
        if (cnt == 0) begin
          check("slice_hold", gs_slice, held_slice);
          shift_busy = 1'b0;
          shift_done = 1'b1;
        end
      end else if (shift_start) begin
        starts++;
        held_slice = gs_slice;
        if (sb.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sel", shift_sel, e.sel);
          if (e.sel == LATCH_SEL_GS) check("slice", gs_slice, e.slice);
        end
        shift_busy = 1'b1;
        cnt = done_delay;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;

    // Reset state, then the initial control load with done 20 cycles later.
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    push(LATCH_SEL_CTRL, 0);
    reset = 1'b0;
    wait_quiet(200, "init");
    check("init_starts", starts, 1);

    // Single ticks in IDLE.
    tick_gs();
    wait_quiet(100, "gs1");
    tick_gs();
    wait_quiet(100, "gs2");

    // Tick event and ctrl_req land on the same cycle: grayscale first.
    model_slice = 3;
    push(LATCH_SEL_GS, 3);
    push(LATCH_SEL_CTRL, 0);
    enc_tick = 1'b1;
    repeat (2) @(negedge clk);
    enc_tick = 1'b0;
    @(negedge clk);
    ctrl_req = 1'b1;
    @(negedge clk);
    ctrl_req = 1'b0;
    wait_quiet(200, "tick_ctrl");

    // Walk the counter up to 359, then wrap to 0.
    done_delay = 3;
    while (model_slice != NS - 1) begin
      tick_gs();
      wait_quiet(60, "bulk");
    end
    tick_gs();
    wait_quiet(60, "wrap");
    check("wrap_model", model_slice, 0);
    check("overrun_bulk", overrun, 0);

    // Home at slice 100 resets the counter.
    for (int i = 0; i < 100; i++) begin
      tick_gs();
      wait_quiet(60, "to100");
    end
    model_slice = 0;
    push(LATCH_SEL_GS, 0);
    enc_home = 1'b1;
    repeat (2) @(negedge clk);
    enc_home = 1'b0;
    repeat (2) @(negedge clk);
    wait_quiet(60, "home");
    tick_gs();
    wait_quiet(60, "after_home");

    // Two ticks during GS_WAIT: overrun, one issue with the newest slice.
    done_delay = 20;
    tick_gs();
    wait_state(GS_WAIT, 50);
    tick_pulse();
    tick_pulse();
    model_slice = model_slice + 2;
    push(LATCH_SEL_GS, model_slice);
    wait_quiet(200, "overrun_issue");
    check("overrun_set", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);

    // Reset mid-upload aborts; control load is re-issued first.
    tick_gs();
    wait_state(GS_WAIT, 50);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge clk);
    model_slice = 0;
    base = starts;
    push(LATCH_SEL_CTRL, 0);
    reset = 1'b0;
    wait_quiet(200, "restart");
    check("restart_starts", starts - base, 1);
    tick_gs();
    wait_quiet(200, "restart_gs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_scheduler.md
LATCH_SCHEDULER -- requirements
Module: latch_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 360: encoder slices per revolution.
REQ-002 SHALL have parameter SW, default $clog2(NUM_SLICES): slice index width.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enc_tick, input, 1: asynchronous per-slice encoder pulse.
REQ-006 SHALL have port enc_home, input, 1: asynchronous absolute-home (index) pulse.
REQ-007 SHALL have port ctrl_req, input, 1: one-cycle request to reload the control latch.
REQ-008 SHALL have port shift_busy, input, 1: shift engine is shifting or latching.
REQ-009 SHALL have port shift_done, input, 1: one-cycle pulse; upload and LAT are complete.
REQ-010 SHALL have port shift_start, output, 1: one-cycle command to the shift engine.
REQ-011 SHALL have port shift_sel, output, 1: latch select for the command; 1 = control, 0 = grayscale.
REQ-012 SHALL have port gs_slice, output, SW: slice number to load; held stable from shift_start until shift_done.
REQ-013 SHALL have port overrun, output, 1: sticky flag; a slice was missed.
REQ-014 SHALL have port overrun_clr, input, 1: clears overrun.
REQ-015 SHALL have port sched_state, output, 3: current state, for STATE_CHECK debug.

Function
REQ-016 SHALL pass enc_tick and enc_home each through a 2-flop synchroniser and then a rising-edge detector; an edge event SHALL occur 3 cycles after the input edge.
REQ-017 SHALL keep slice counter cur_slice: +1 per tick event, wrapping NUM_SLICES-1 -> 0; a home event SHALL set it to 0; home wins over a simultaneous tick.
REQ-018 SHALL latch ctrl_pend on ctrl_req and clear it only when a control upload is issued.
REQ-019 SHALL set gs_pend on each tick or home event and clear it when a grayscale upload is issued.
REQ-020 SHALL use states INIT_CTRL(0), INIT_WAIT(1), IDLE(2), GS_ISSUE(3), GS_WAIT(4), CTRL_ISSUE(5), CTRL_WAIT(6).
REQ-021 After reset SHALL go INIT_CTRL -> assert shift_start with shift_sel=1 -> INIT_WAIT; grayscale SHALL NOT be issued before the first shift_done.
REQ-022 In IDLE, gs_pend SHALL win over ctrl_pend (display timing priority); ctrl_pend SHALL be served on the first IDLE cycle with gs_pend=0.
REQ-023 Issue states SHALL wait while shift_busy=1, then pulse shift_start for exactly 1 cycle and capture gs_slice=cur_slice in GS_ISSUE.
REQ-024 Wait states SHALL return to IDLE on shift_done; a shift_done in any other state SHALL be ignored.
REQ-025 A tick event while gs_pend=1 SHALL set overrun; gs_pend SHALL stay 1 and gs_slice SHALL take the newest slice at issue.
REQ-026 overrun_clr SHALL clear overrun; a simultaneous set event SHALL win.
REQ-027 Issue latency SHALL be 1 cycle: from an event in IDLE with shift_busy=0, shift_start SHALL occur on the cycle after the state moves to the issue state.

Reset
REQ-028 On reset SHALL set: shift_start=0, shift_sel=1, gs_slice=0, overrun=0, sched_state=INIT_CTRL, cur_slice=0, ctrl_pend=0, gs_pend=0, synchronisers=0.
REQ-029 Reset asserted mid-upload SHALL abort immediately; after release the block SHALL restart at INIT_CTRL regardless of shift_busy.

Structure
REQ-030 SHALL take the state enum, the LATCH_SEL_CTRL/LATCH_SEL_GS constants and the NUM_SLICES default from shared package voxel_pkg.
REQ-031 SHALL instantiate one sub-module, sync_edge (2-flop synchroniser plus rising-edge detect), once each for enc_tick and enc_home.

Verification
REQ-032 Reset release, shift_done 20 cycles after start -> exactly one shift_start with shift_sel=1, then IDLE; no grayscale start before that.
REQ-033 A tick event while in IDLE -> shift_start with shift_sel=0 and gs_slice=1; a second tick -> gs_slice=2.
REQ-034 Tick and ctrl_req on the same cycle in IDLE -> grayscale issued first, control issued right after its shift_done.
REQ-035 359 ticks then 1 tick -> slice counter wraps to 0; a home event at cur_slice=100 -> next gs_slice=0.
REQ-036 Two ticks during GS_WAIT -> overrun=1, one grayscale issue with the newest slice; overrun_clr -> overrun=0.
REQ-037 Reset asserted in GS_WAIT -> all outputs at reset values on the next edge; after release, control upload is re-issued first.
